// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: widths, opcode, forwarding
// and multiplier state encodings.
package exe_stage_pkg;

    localparam int DSIZE = 16;   // datapath width
    localparam int ASIZE = 5;    // register-address width
    localparam int ISIZE = 16;   // PC width

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_SLT  = 3'b100,
        OP_MUL  = 3'b101,
        OP_XOR  = 3'b110,
        OP_ZERO = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_REG     = 2'b00,
        FWD_EXMEM   = 2'b01,
        FWD_MEMWB   = 2'b10,
        FWD_REG_ALT = 2'b11
    } fwd_sel_t;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_BUSY = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_t;

endpackage

// File: rtl/exe_stage_if.sv
// ID/EXE -> EXE -> EXE/MEM signal bundle of the execute stage.
// master = upstream/downstream pipeline side, slave = exe_stage.
interface exe_stage_if;
    import exe_stage_pkg::*;

    logic [DSIZE-1:0] rdata1_in;
    logic [DSIZE-1:0] rdata2_in;
    logic [DSIZE-1:0] imm_in;
    logic [ISIZE-1:0] PC_in;
    logic [2:0]       opcode_in;
    logic             alusrc_in;
    logic [ASIZE-1:0] waddr_in;
    logic             wen_in;
    logic             memWrite_in;
    logic             memRead_in;
    logic             memToReg_in;
    logic             branch_in;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic [DSIZE-1:0] exmem_fwd_data;
    logic [DSIZE-1:0] memwb_fwd_data;

    logic [DSIZE-1:0] alu_result_out;
    logic [DSIZE-1:0] store_data_out;
    logic [ASIZE-1:0] waddr_out;
    logic             wen_out;
    logic             memWrite_out;
    logic             memRead_out;
    logic             memToReg_out;
    logic             branch_taken_out;
    logic [ISIZE-1:0] branch_target_out;
    logic             stall_out;

    modport master (
        output rdata1_in, rdata2_in, imm_in, PC_in, opcode_in, alusrc_in,
               waddr_in, wen_in, memWrite_in, memRead_in, memToReg_in,
               branch_in, fwd_a_sel, fwd_b_sel, exmem_fwd_data, memwb_fwd_data,
        input  alu_result_out, store_data_out, waddr_out, wen_out,
               memWrite_out, memRead_out, memToReg_out, branch_taken_out,
               branch_target_out, stall_out
    );

    modport slave (
        input  rdata1_in, rdata2_in, imm_in, PC_in, opcode_in, alusrc_in,
               waddr_in, wen_in, memWrite_in, memRead_in, memToReg_in,
               branch_in, fwd_a_sel, fwd_b_sel, exmem_fwd_data, memwb_fwd_data,
        output alu_result_out, store_data_out, waddr_out, wen_out,
               memWrite_out, memRead_out, memToReg_out, branch_taken_out,
               branch_target_out, stall_out
    );

endinterface

// File: rtl/exe_stage_seq_mul.sv
// Sequential shift-add multiplier: one partial product per cycle,
// WIDTH busy cycles, then a single DONE cycle holding the product.
module seq_mul
    import exe_stage_pkg::*;
#(
    parameter int WIDTH = DSIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    mul_state_t       state_r;
    mul_state_t       state_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= MUL_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state: the last busy step is the one with cnt = WIDTH-1
    always_comb begin
        state_s = state_r;
        case (state_r)
            MUL_IDLE: begin
                if (start) begin
                    state_s = MUL_BUSY;
                end else begin
                    state_s = MUL_IDLE;
                end
            end
            MUL_BUSY: begin
                if (cnt_r == CW'(WIDTH - 1)) begin
                    state_s = MUL_DONE;
                end else begin
                    state_s = MUL_BUSY;
                end
            end
            MUL_DONE: state_s = MUL_IDLE;
            default:  state_s = MUL_IDLE;
        endcase
    end

    // Operand capture and one shift-add step per busy cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= {CW{1'b0}};
            acc_r    <= {WIDTH{1'b0}};
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                MUL_IDLE: begin
                    cnt_r <= {CW{1'b0}};
                    if (start) begin
                        acc_r    <= {WIDTH{1'b0}};
                        mcand_r  <= a;
                        mplier_r <= b;
                    end
                end
                MUL_BUSY: begin
                    if (mplier_r[0]) begin
                        acc_r <= acc_r + mcand_r;
                    end
                    mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
                    cnt_r    <= cnt_r + CW'(1);
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign busy    = (state_r == MUL_BUSY);
    assign done    = (state_r == MUL_DONE);
    assign product = acc_r;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, branch resolution
// and a stalling sequential multiplier, registered into EXE/MEM.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    exe_stage_if.slave  bus
);

    logic [DSIZE-1:0] fwd_a_s;
    logic [DSIZE-1:0] fwd_b_s;
    logic [DSIZE-1:0] op_b_s;
    logic [DSIZE-1:0] alu_s;
    logic [DSIZE-1:0] product_s;
    logic [DSIZE-1:0] cap_a_r;
    logic [DSIZE-1:0] cap_b_r;
    logic [ISIZE-1:0] target_s;
    logic             mul_start_s;
    logic             mul_busy_s;
    logic             mul_done_s;
    logic             stall_s;

    // Forwarding muxes and the alusrc select for operand B
    always_comb begin
        fwd_a_s = bus.rdata1_in;
        fwd_b_s = bus.rdata2_in;
        case (bus.fwd_a_sel)
            FWD_EXMEM: fwd_a_s = bus.exmem_fwd_data;
            FWD_MEMWB: fwd_a_s = bus.memwb_fwd_data;
            default:   fwd_a_s = bus.rdata1_in;
        endcase
        case (bus.fwd_b_sel)
            FWD_EXMEM: fwd_b_s = bus.exmem_fwd_data;
            FWD_MEMWB: fwd_b_s = bus.memwb_fwd_data;
            default:   fwd_b_s = bus.rdata2_in;
        endcase
        if (bus.alusrc_in) begin
            op_b_s = bus.imm_in;
        end else begin
            op_b_s = fwd_b_s;
        end
    end

    // Single-cycle ALU; MUL is produced by seq_mul instead
    always_comb begin
        alu_s = {DSIZE{1'b0}};
        case (bus.opcode_in)
            OP_ADD: alu_s = fwd_a_s + op_b_s;
            OP_SUB: alu_s = fwd_a_s - op_b_s;
            OP_AND: alu_s = fwd_a_s & op_b_s;
            OP_OR:  alu_s = fwd_a_s | op_b_s;
            OP_SLT: begin
                if ($signed(fwd_a_s) < $signed(op_b_s)) begin
                    alu_s = {{(DSIZE-1){1'b0}}, 1'b1};
                end else begin
                    alu_s = {DSIZE{1'b0}};
                end
            end
            OP_XOR: alu_s = fwd_a_s ^ op_b_s;
            default: alu_s = {DSIZE{1'b0}};
        endcase
    end

    // A new multiply starts only from IDLE, so a held MUL in DONE is not re-run
    assign mul_start_s = (bus.opcode_in == OP_MUL) && !mul_busy_s && !mul_done_s;
    assign stall_s     = !rst && (mul_start_s || mul_busy_s);
    assign target_s    = bus.PC_in + ISIZE'(bus.imm_in);
    assign bus.stall_out = stall_s;

    seq_mul #(.WIDTH(DSIZE)) u_seq_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start_s),
        .a       (fwd_a_s),
        .b       (op_b_s),
        .busy    (mul_busy_s),
        .done    (mul_done_s),
        .product (product_s)
    );

    // Forwarded operands frozen at multiply start; forwarding buses may move on
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_a_r <= {DSIZE{1'b0}};
            cap_b_r <= {DSIZE{1'b0}};
        end else if (mul_start_s) begin
            cap_a_r <= fwd_a_s;
            cap_b_r <= fwd_b_s;
        end
    end

    // EXE/MEM register: bubble while stalled, product in DONE, ALU otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.alu_result_out    <= {DSIZE{1'b0}};
            bus.store_data_out    <= {DSIZE{1'b0}};
            bus.waddr_out         <= {ASIZE{1'b0}};
            bus.wen_out           <= 1'b0;
            bus.memWrite_out      <= 1'b0;
            bus.memRead_out       <= 1'b0;
            bus.memToReg_out      <= 1'b0;
            bus.branch_taken_out  <= 1'b0;
            bus.branch_target_out <= {ISIZE{1'b0}};
        end else begin
            bus.branch_target_out <= target_s;
            if (stall_s) begin
                bus.alu_result_out   <= {DSIZE{1'b0}};
                bus.store_data_out   <= {DSIZE{1'b0}};
                bus.waddr_out        <= {ASIZE{1'b0}};
                bus.wen_out          <= 1'b0;
                bus.memWrite_out     <= 1'b0;
                bus.memRead_out      <= 1'b0;
                bus.memToReg_out     <= 1'b0;
                bus.branch_taken_out <= 1'b0;
            end else begin
                bus.waddr_out    <= bus.waddr_in;
                bus.wen_out      <= bus.wen_in;
                bus.memWrite_out <= bus.memWrite_in;
                bus.memRead_out  <= bus.memRead_in;
                bus.memToReg_out <= bus.memToReg_in;
                if (mul_done_s) begin
                    bus.alu_result_out   <= product_s;
                    bus.store_data_out   <= cap_b_r;
                    bus.branch_taken_out <= bus.branch_in && (cap_a_r == cap_b_r);
                end else begin
                    bus.alu_result_out   <= alu_s;
                    bus.store_data_out   <= fwd_b_s;
                    bus.branch_taken_out <= bus.branch_in && (fwd_a_s == fwd_b_s);
                end
            end
        end
    end

endmodule
